// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-register constants: bubble encodings and reset PC for the CPU stage registers.
// Constants are held wide and sliced down to each stage's parameter widths.
package cpu_pipe_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int CTRL_W_DEF   = 8;
    localparam int REGIDX_W_DEF = 4;
    localparam int CNT_W_DEF    = 8;

    // Wide patterns; a stage takes the low CTRL_W / REGIDX_W / ADDR_W bits.
    localparam logic [63:0] NEXT      = 64'h1;
    localparam logic [63:0] EMPTY     = 64'hB;
    localparam logic [63:0] idx_EMPTY = '1;
    localparam logic [63:0] PC_START  = 64'h0;

    typedef struct packed {
        logic [CTRL_W_DEF-1:0]   pcsrc;
        logic [CTRL_W_DEF-1:0]   wbsrc;
        logic [REGIDX_W_DEF-1:0] wbreg;
        logic                    mem_read;
        logic                    mem_write;
        logic                    zero;
        logic                    valid;
    } bubble_ctrl_t;

    // Control bundle of an empty slot at default widths, shared with ID/EXE and MEM/WB.
    localparam bubble_ctrl_t BUBBLE_CTRL = '{
        pcsrc:     NEXT[CTRL_W_DEF-1:0],
        wbsrc:     EMPTY[CTRL_W_DEF-1:0],
        wbreg:     idx_EMPTY[REGIDX_W_DEF-1:0],
        mem_read:  1'b0,
        mem_write: 1'b0,
        zero:      1'b0,
        valid:     1'b0
    };

    function automatic logic sat_full(input logic [63:0] cnt, input int w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return cnt == lim;
    endfunction

endpackage

// File: rtl/pipe_hold_reg.sv
// Generic stage register: synchronous clear-to-value beats load, otherwise hold.
module pipe_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] clr_val,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= clr_val;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/exmem_pipe_reg.sv
// EXE/MEM stage register with stall, flush, valid tracking and a saturating bubble counter.
// Control and data bundles live in separate hold registers because flush treats them differently.
module exmem_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int CTRL_W   = 8,
    parameter int REGIDX_W = 4,
    parameter int CNT_W    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                boot,
    input  logic                stall,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [CTRL_W-1:0]   PCSrc_in,
    input  logic [CTRL_W-1:0]   WBSrc_in,
    input  logic                MemRead_in,
    input  logic                MemWrite_in,
    input  logic                zero_in,
    input  logic [REGIDX_W-1:0] WBReg_in,
    input  logic [ADDR_W-1:0]   pc_branch8_in,
    input  logic [ADDR_W-1:0]   pc_branch11_in,
    input  logic [ADDR_W-1:0]   pc_jump_in,
    input  logic [DATA_W-1:0]   ALU_result_in,
    input  logic [DATA_W-1:0]   MemData_in,
    output logic [CTRL_W-1:0]   PCSrc_out,
    output logic [CTRL_W-1:0]   WBSrc_out,
    output logic                MemRead_out,
    output logic                MemWrite_out,
    output logic                zero_out,
    output logic [REGIDX_W-1:0] WBReg_out,
    output logic [ADDR_W-1:0]   pc_branch8_out,
    output logic [ADDR_W-1:0]   pc_branch11_out,
    output logic [ADDR_W-1:0]   pc_jump_out,
    output logic [DATA_W-1:0]   ALU_result_out,
    output logic [DATA_W-1:0]   MemData_out,
    output logic                valid_out,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam int CTL_BITS = 2*CTRL_W + REGIDX_W + 4;
    localparam int DAT_BITS = 3*ADDR_W + 2*DATA_W;

    localparam logic [CTL_BITS-1:0] CTL_BUBBLE =
        {NEXT[CTRL_W-1:0], EMPTY[CTRL_W-1:0], idx_EMPTY[REGIDX_W-1:0], 4'b0000};
    localparam logic [DAT_BITS-1:0] DAT_RESET =
        {{3{PC_START[ADDR_W-1:0]}}, {(2*DATA_W){1'b0}}};

    logic                clr;
    logic                bubble_evt;
    logic                ctl_load;
    logic                dat_load;
    logic [CTL_BITS-1:0] ctl_in;
    logic [CTL_BITS-1:0] ctl_d;
    logic [CTL_BITS-1:0] ctl_q;
    logic [DAT_BITS-1:0] dat_in;
    logic [DAT_BITS-1:0] dat_q;

    // Reset and boot-hold share the same clear value; only RST touches the counter.
    assign clr        = RST | ~boot;
    assign bubble_evt = flush | (~stall & ~valid_in);
    assign ctl_load   = flush | ~stall;
    assign dat_load   = ~flush & ~stall;

    assign ctl_in = {PCSrc_in, WBSrc_in, WBReg_in, MemRead_in, MemWrite_in, zero_in, 1'b1};
    assign ctl_d  = bubble_evt ? CTL_BUBBLE : ctl_in;
    assign dat_in = {pc_branch8_in, pc_branch11_in, pc_jump_in, ALU_result_in, MemData_in};

    pipe_hold_reg #(.WIDTH(CTL_BITS)) u_ctl (
        .clk     (CLK),
        .clr     (clr),
        .clr_val (CTL_BUBBLE),
        .load    (ctl_load),
        .d       (ctl_d),
        .q       (ctl_q)
    );

    // Data holds through a flush so forwarding still sees the last real values.
    pipe_hold_reg #(.WIDTH(DAT_BITS)) u_dat (
        .clk     (CLK),
        .clr     (clr),
        .clr_val (DAT_RESET),
        .load    (dat_load),
        .d       (dat_in),
        .q       (dat_q)
    );

    assign {PCSrc_out, WBSrc_out, WBReg_out, MemRead_out, MemWrite_out, zero_out, valid_out} = ctl_q;
    assign {pc_branch8_out, pc_branch11_out, pc_jump_out, ALU_result_out, MemData_out} = dat_q;

    always_ff @(posedge CLK) begin
        if (RST)
            bubble_cnt <= '0;
        else if (boot && bubble_evt && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + 1'b1;
    end

    a_no_ghost_store: assert property (@(posedge CLK) !(MemWrite_out && !valid_out));

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Randomized/directed bench for exmem_pipe_reg against a per-edge behavioural model.
module tb_exmem_pipe_reg;

    typedef struct packed {
        logic rst, boot, stall, flush, vin;
        logic [7:0] pcsrc, wbsrc;
        logic [3:0] wbreg;
        logic mr, mw, z;
        logic [15:0] b8, b11, j, alu, md;
    } in_t;

    typedef struct packed {
        logic [7:0] pcsrc, wbsrc;
        logic [3:0] wbreg;
        logic mr, mw, z, v;
        logic [15:0] b8, b11, j, alu, md;
        logic [7:0] cnt;
    } out_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    in_t  cur;
    out_t obs, exp;
    int   checks = 0;
    int   passes = 0;

    logic [7:0]  PCSrc_out, WBSrc_out, bubble_cnt;
    logic [3:0]  WBReg_out;
    logic        MemRead_out, MemWrite_out, zero_out, valid_out;
    logic [15:0] pc_branch8_out, pc_branch11_out, pc_jump_out, ALU_result_out, MemData_out;

    exmem_pipe_reg dut (
        .CLK(CLK), .RST(cur.rst), .boot(cur.boot), .stall(cur.stall), .flush(cur.flush),
        .valid_in(cur.vin), .PCSrc_in(cur.pcsrc), .WBSrc_in(cur.wbsrc),
        .MemRead_in(cur.mr), .MemWrite_in(cur.mw), .zero_in(cur.z), .WBReg_in(cur.wbreg),
        .pc_branch8_in(cur.b8), .pc_branch11_in(cur.b11), .pc_jump_in(cur.j),
        .ALU_result_in(cur.alu), .MemData_in(cur.md),
        .PCSrc_out(PCSrc_out), .WBSrc_out(WBSrc_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .zero_out(zero_out), .WBReg_out(WBReg_out),
        .pc_branch8_out(pc_branch8_out), .pc_branch11_out(pc_branch11_out),
        .pc_jump_out(pc_jump_out), .ALU_result_out(ALU_result_out), .MemData_out(MemData_out),
        .valid_out(valid_out), .bubble_cnt(bubble_cnt)
    );

    assign obs = '{pcsrc: PCSrc_out, wbsrc: WBSrc_out, wbreg: WBReg_out, mr: MemRead_out,
                   mw: MemWrite_out, z: zero_out, v: valid_out, b8: pc_branch8_out,
                   b11: pc_branch11_out, j: pc_jump_out, alu: ALU_result_out,
                   md: MemData_out, cnt: bubble_cnt};

    function automatic out_t bubble_ctl(input out_t p);
        out_t n = p;
        n.pcsrc = 8'h01; n.wbsrc = 8'h0B; n.wbreg = 4'hF;
        n.mr = 1'b0; n.mw = 1'b0; n.z = 1'b0; n.v = 1'b0;
        return n;
    endfunction

    function automatic out_t model(input out_t p, input in_t i);
        out_t n = p;
        if (i.rst || !i.boot) begin
            n = bubble_ctl(n);
            n.b8 = 0; n.b11 = 0; n.j = 0; n.alu = 0; n.md = 0;
            if (i.rst) n.cnt = 0;
        end else if (i.flush) begin
            n = bubble_ctl(n);
            if (n.cnt != 8'hFF) n.cnt = n.cnt + 8'd1;
        end else if (!i.stall) begin
            n.b8 = i.b8; n.b11 = i.b11; n.j = i.j; n.alu = i.alu; n.md = i.md;
            if (i.vin) begin
                n.pcsrc = i.pcsrc; n.wbsrc = i.wbsrc; n.wbreg = i.wbreg;
                n.mr = i.mr; n.mw = i.mw; n.z = i.z; n.v = 1'b1;
            end else begin
                n = bubble_ctl(n);
                if (n.cnt != 8'hFF) n.cnt = n.cnt + 8'd1;
            end
        end
        return n;
    endfunction

    task automatic rand_data();
        cur.pcsrc = 8'($urandom); cur.wbsrc = 8'($urandom); cur.wbreg = 4'($urandom);
        cur.mr = 1'($urandom); cur.mw = 1'($urandom); cur.z = 1'($urandom);
        cur.b8 = 16'($urandom); cur.b11 = 16'($urandom); cur.j = 16'($urandom);
        cur.alu = 16'($urandom); cur.md = 16'($urandom);
    endtask

    task automatic tick();
        @(posedge CLK);
        exp = model(exp, cur);
        #1;
    endtask

    task automatic test_reset();
        rand_data();
        cur.rst = 1; cur.boot = 1; cur.vin = 1;
        cur.stall = 1'($urandom); cur.flush = 1'($urandom);
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (obs !== exp) $display("FAIL reset_model got %h want %h", obs, exp); else passes++;
        end
        checks++; if (obs.pcsrc !== 8'h01) $display("FAIL reset_pcsrc got %h want 01", obs.pcsrc); else passes++;
        checks++; if (obs.wbsrc !== 8'h0B) $display("FAIL reset_wbsrc got %h want 0b", obs.wbsrc); else passes++;
        checks++; if (obs.wbreg !== 4'hF) $display("FAIL reset_wbreg got %h want f", obs.wbreg); else passes++;
        checks++; if ({obs.b8, obs.b11, obs.j} !== 48'h0) $display("FAIL reset_pc got %h want 0", {obs.b8, obs.b11, obs.j}); else passes++;
        checks++; if (obs.v !== 1'b0 || obs.cnt !== 8'h00) $display("FAIL reset_valid_cnt got %b/%h want 0/00", obs.v, obs.cnt); else passes++;
    endtask

    task automatic test_load_stall();
        rand_data();
        cur.rst = 0; cur.boot = 1; cur.stall = 0; cur.flush = 0; cur.vin = 1;
        cur.alu = 16'h1234; cur.wbreg = 4'd3; cur.mw = 1;
        tick();
        checks++; if (obs !== exp) $display("FAIL load_model got %h want %h", obs, exp); else passes++;
        checks++; if (obs.alu !== 16'h1234 || obs.v !== 1'b1) $display("FAIL load_alu_valid got %h/%b want 1234/1", obs.alu, obs.v); else passes++;
        cur.stall = 1; cur.alu = 16'hFFFF; cur.wbreg = 4'hF; cur.mw = 0; cur.b8 = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({obs.alu, obs.wbreg, obs.mw} !== {16'h1234, 4'd3, 1'b1})
                $display("FAIL stall_hold got %h/%h/%b want 1234/3/1", obs.alu, obs.wbreg, obs.mw);
            else passes++;
        end
        checks++; if (obs !== exp) $display("FAIL stall_model got %h want %h", obs, exp); else passes++;
    endtask

    task automatic test_flush_stall();
        logic [7:0] c0;
        rand_data();
        cur.stall = 0; cur.flush = 0; cur.vin = 1; cur.alu = 16'hBEEF; cur.mw = 1;
        tick();
        c0 = exp.cnt;
        rand_data();
        cur.stall = 1; cur.flush = 1; cur.mw = 1;
        tick();
        checks++;
        if ({obs.pcsrc, obs.wbsrc, obs.wbreg, obs.mw, obs.v} !== {8'h01, 8'h0B, 4'hF, 1'b0, 1'b0})
            $display("FAIL flush_ctrl got %h/%h/%h/%b/%b want 01/0b/f/0/0", obs.pcsrc, obs.wbsrc, obs.wbreg, obs.mw, obs.v);
        else passes++;
        checks++; if (obs.alu !== 16'hBEEF) $display("FAIL flush_data got %h want beef", obs.alu); else passes++;
        checks++; if (obs.cnt !== c0 + 8'd1) $display("FAIL flush_cnt got %h want %h", obs.cnt, c0 + 8'd1); else passes++;
    endtask

    task automatic test_invalid();
        logic [7:0] c0;
        c0 = exp.cnt;
        rand_data();
        cur.stall = 0; cur.flush = 0; cur.vin = 0; cur.mw = 1; cur.alu = 16'h00AA;
        tick();
        checks++; if (obs.mw !== 1'b0 || obs.v !== 1'b0) $display("FAIL invalid_ctrl got %b/%b want 0/0", obs.mw, obs.v); else passes++;
        checks++; if (obs.alu !== 16'h00AA) $display("FAIL invalid_data got %h want 00aa", obs.alu); else passes++;
        checks++; if (obs.cnt !== c0 + 8'd1) $display("FAIL invalid_cnt got %h want %h", obs.cnt, c0 + 8'd1); else passes++;
    endtask

    task automatic test_boot();
        logic [7:0] c0;
        c0 = exp.cnt;
        cur.boot = 0; cur.vin = 1; cur.stall = 0;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            cur.flush = 1'($urandom);
            tick();
            checks++; if (obs !== exp) $display("FAIL boot_model got %h want %h", obs, exp); else passes++;
        end
        checks++; if (obs.alu !== 16'h0 || obs.cnt !== c0) $display("FAIL boot_hold got %h/%h want 0000/%h", obs.alu, obs.cnt, c0); else passes++;
        rand_data();
        cur.boot = 1; cur.flush = 0; cur.alu = 16'h5A5A;
        tick();
        checks++; if (obs.alu !== 16'h5A5A || obs.v !== 1'b1) $display("FAIL boot_release got %h/%b want 5a5a/1", obs.alu, obs.v); else passes++;
    endtask

    task automatic test_saturate();
        int bad = 0;
        cur.flush = 1; cur.stall = 0;
        for (int k = 0; k < 260; k++) begin
            rand_data();
            tick();
            if (obs !== exp) bad++;
        end
        checks++; if (bad != 0) $display("FAIL sat_model got %0d bad cycles want 0", bad); else passes++;
        checks++; if (obs.cnt !== 8'hFF) $display("FAIL sat_cnt got %h want ff", obs.cnt); else passes++;
        cur.flush = 0; cur.rst = 1;
        tick();
        checks++; if (obs.cnt !== 8'h00) $display("FAIL sat_reset got %h want 00", obs.cnt); else passes++;
        cur.rst = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rand_data();
            cur.rst   = ($urandom_range(0, 49) == 0);
            cur.boot  = ($urandom_range(0, 19) != 0);
            cur.flush = ($urandom_range(0, 5) == 0);
            cur.stall = ($urandom_range(0, 3) == 0);
            cur.vin   = ($urandom_range(0, 3) != 0);
            tick();
            checks++; if (obs !== exp) $display("FAIL random_%0d got %h want %h", k, obs, exp); else passes++;
        end
    endtask

    initial begin
        cur = '0;
        exp = '0;
        test_reset();
        test_load_stall();
        test_flush_stall();
        test_invalid();
        test_boot();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
